// File: rtl/bitrev_reorder_buffer.sv
// ============================================================================
// Module   : bitrev_reorder_buffer
// Brief    : Ping-pong frame buffer that writes natural-order samples to
//            bit-reversed addresses and streams frames out sequentially.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitrev_reorder_buffer #(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last
);

    localparam int               c_N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_LAST = {LOG2N{1'b1}};

    logic [DATA_W-1:0] r_mem [2][c_N];

    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [LOG2N-1:0]  r_wr_cnt;
    logic [LOG2N-1:0]  r_rd_cnt;
    logic [1:0]        r_full;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [LOG2N-1:0]  r_out_index;
    logic              r_out_last;

    logic [LOG2N-1:0]  w_wr_addr;
    logic              w_in_accept;
    logic              w_load;
    logic              w_set_full;
    logic              w_clr_full;

    // Write address is the bit-reversed write counter (pure wiring).
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
        assign w_wr_addr[gi] = r_wr_cnt[LOG2N-1-gi];
    end

    assign in_ready    = ~r_full[r_wr_bank];
    assign w_in_accept = in_valid & in_ready;
    assign w_load      = r_full[r_rd_bank] & (~r_out_valid | out_ready);
    assign w_set_full  = w_in_accept & (r_wr_cnt == c_LAST);
    assign w_clr_full  = w_load & (r_rd_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst && w_in_accept) begin
            r_mem[r_wr_bank][w_wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (w_in_accept) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_set_full) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Set and clear can never target the same bank: set needs an empty bank,
    // clear needs a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            if (w_set_full) begin
                r_full[r_wr_bank] <= 1'b1;
            end
            if (w_clr_full) begin
                r_full[r_rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_mem[r_rd_bank][r_rd_cnt];
            r_out_index <= r_rd_cnt;
            r_out_last  <= (r_rd_cnt == c_LAST);
            r_out_valid <= 1'b1;
            r_rd_cnt    <= r_rd_cnt + 1'b1;
            if (w_clr_full) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_bitrev_reorder_buffer.sv
// ============================================================================
// Module   : tb_bitrev_reorder_buffer
// Brief    : Directed self-checking bench for bitrev_reorder_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitrev_reorder_buffer;

    localparam int DATA_W = 32;
    localparam int LOG2N  = 5;
    localparam int N      = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [LOG2N-1:0]  out_index;
    logic              out_last;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] rnd_vals [10*N];

    bitrev_reorder_buffer #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] brev(input logic [4:0] x);
        logic [4:0] r;
        for (int b = 0; b < 5; b++) r[b] = x[4-b];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            step();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_out_valid cyc %0d: got %b expected 0", i, out_valid);
            end
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        n_vec++;
        if (in_ready !== 1'b1 || out_last !== 1'b0 || out_index !== 5'd0 || out_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_state: in_ready=%b last=%b idx=%0d data=%0h expected 1/0/0/0",
                     in_ready, out_last, out_index, out_data);
        end
    endtask

    task automatic test_single_frame();
        int head [8] = '{0, 16, 8, 24, 4, 20, 12, 28};
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_data = i;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL sf_in_ready sample %0d: got %b expected 1", i, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sf_latency_early: out_valid got %b expected 0", out_valid);
        end
        step();
        for (int j = 0; j < N; j++) begin
            exp_d = (j < 8) ? head[j] : int'(brev(j[4:0]));
            n_vec++;
            if (out_valid !== 1'b1 || out_index !== j[4:0] || out_data !== exp_d ||
                out_last !== (j == N-1)) begin
                n_err++;
                $display("FAIL sf_out %0d: v=%b idx=%0d data=%0h last=%b expected 1/%0d/%0h/%b",
                         j, out_valid, out_index, out_data, out_last, j, exp_d, (j == N-1));
            end
            step();
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sf_end: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, cyc = 0;
        logic acc;
        logic [4:0] idx;
        logic [31:0] exp_d;
        out_ready = 1'b1;
        while (got < 4*N && cyc < 400) begin
            in_valid = (sent < 4*N);
            in_data  = sent;
            if (in_valid) begin
                n_vec++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_in_ready sample %0d: got %b expected 1", sent, in_ready);
                end
            end
            if (out_valid) begin
                idx   = 5'(got % N);
                exp_d = (got / N) * N + int'(brev(idx));
                n_vec++;
                if (out_index !== idx || out_data !== exp_d || out_last !== (idx == 5'd31)) begin
                    n_err++;
                    $display("FAIL b2b_out %0d: idx=%0d data=%0h last=%b expected %0d/%0h/%b",
                             got, out_index, out_data, out_last, idx, exp_d, (idx == 5'd31));
                end
                got++;
            end else if (got > 0) begin
                n_vec++; n_err++;
                $display("FAIL b2b_bubble after %0d outputs: out_valid got 0 expected 1", got);
            end
            acc = in_valid & in_ready;
            step();
            cyc++;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 4*N) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs expected %0d", got, 4*N);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, cyc = 0;
        logic [4:0] idx;
        logic [31:0] exp_d;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        while (cyc < 100) begin
            in_data = sent;
            if (!in_ready) break;
            step();
            sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (sent != 2*N) begin
            n_err++;
            $display("FAIL bp_accepted: got %0d expected %0d", sent, 2*N);
        end
        for (int h = 0; h < 3; h++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 32'd0 || out_index !== 5'd0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold %0d: v=%b data=%0h idx=%0d rdy=%b expected 1/0/0/0",
                         h, out_valid, out_data, out_index, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        cyc = 0;
        while (got < 2*N && cyc < 200) begin
            if (out_valid) begin
                idx   = 5'(got % N);
                exp_d = (got / N) * N + int'(brev(idx));
                n_vec++;
                if (out_index !== idx || out_data !== exp_d || out_last !== (idx == 5'd31)) begin
                    n_err++;
                    $display("FAIL bp_out %0d: idx=%0d data=%0h last=%b expected %0d/%0h/%b",
                             got, out_index, out_data, out_last, idx, exp_d, (idx == 5'd31));
                end
                if (got < N) begin
                    n_vec++;
                    if (in_ready !== (got == N-1)) begin
                        n_err++;
                        $display("FAIL bp_in_ready at output %0d: got %b expected %b",
                                 got, in_ready, (got == N-1));
                    end
                end
                got++;
            end
            step();
            cyc++;
        end
        n_vec++;
        if (got != 2*N || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: outputs=%0d v=%b rdy=%b expected %0d/0/1",
                     got, out_valid, in_ready, 2*N);
        end
    endtask

    task automatic test_random_stalls();
        int sent = 0, got = 0, cyc = 0;
        logic acc, hold, p_valid, p_last;
        logic [4:0] idx, p_idx;
        logic [31:0] exp_d, p_data;
        for (int i = 0; i < 10*N; i++) rnd_vals[i] = $urandom;
        while (got < 10*N && cyc < 4000) begin
            in_valid  = (sent < 10*N) && ($urandom_range(0, 1) == 1);
            in_data   = (sent < 10*N) ? rnd_vals[sent] : 32'd0;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                idx   = 5'(got % N);
                exp_d = rnd_vals[(got / N) * N + int'(brev(idx))];
                n_vec++;
                if (out_index !== idx || out_data !== exp_d || out_last !== (idx == 5'd31)) begin
                    n_err++;
                    $display("FAIL rs_out %0d: idx=%0d data=%0h last=%b expected %0d/%0h/%b",
                             got, out_index, out_data, out_last, idx, exp_d, (idx == 5'd31));
                end
                got++;
            end
            hold = out_valid & ~out_ready;
            p_valid = out_valid; p_data = out_data; p_idx = out_index; p_last = out_last;
            acc = in_valid & in_ready;
            step();
            cyc++;
            if (acc) sent++;
            if (hold) begin
                n_vec++;
                if (out_valid !== p_valid || out_data !== p_data || out_index !== p_idx ||
                    out_last !== p_last) begin
                    n_err++;
                    $display("FAIL rs_stable cyc %0d: v=%b data=%0h idx=%0d last=%b expected %b/%0h/%0d/%b",
                             cyc, out_valid, out_data, out_index, out_last, p_valid, p_data, p_idx, p_last);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (got != 10*N) begin
            n_err++;
            $display("FAIL rs_count: got %0d outputs expected %0d", got, 10*N);
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        int sent = 0, got = 0, cyc = 0, stale = 0;
        logic acc;
        logic [31:0] exp_d;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 500 + i;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rm_after_rst: v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        while (got < N && cyc < 100) begin
            in_valid = (sent < N);
            in_data  = 100 + sent;
            if (out_valid) begin
                exp_d = 100 + int'(brev(5'(got)));
                n_vec++;
                if (out_index !== 5'(got) || out_data !== exp_d || out_last !== (got == N-1)) begin
                    n_err++;
                    $display("FAIL rm_out %0d: idx=%0d data=%0h last=%b expected %0d/%0h/%b",
                             got, out_index, out_data, out_last, got, exp_d, (got == N-1));
                end
                got++;
            end
            acc = in_valid & in_ready;
            step();
            cyc++;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) stale++;
            step();
        end
        n_vec++;
        if (got != N || stale != 0) begin
            n_err++;
            $display("FAIL rm_frame: outputs=%0d stale=%0d expected %0d/0", got, stale, N);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random_stalls();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
